// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that time-shares one external serial sequence detector
// among NREQ requesters and returns the per-job hit count.
module seq_detect_scheduler #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WORD_W-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       det_i,
    output logic                       det_reset,
    input  logic                       det_out,
    output logic                       rsp_valid,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [CNT_W-1:0]           rsp_count,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned BIT_W = $clog2(WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        RESP
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [WORD_W-1:0]  word;
    logic [BIT_W-1:0]   bit_cnt;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    int unsigned        cand;

    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(rr_ptr) + i) % NREQ;
            if (!gnt_found && req_valid[ID_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

    // The accept pulse must land in the grant cycle itself, so it is decoded
    // from the IDLE state rather than registered.
    always_comb begin
        req_ready = '0;
        if (!reset && state == IDLE && gnt_found)
            req_ready = NREQ'(1) << gnt_idx;
    end

    assign det_reset = reset | (state == CLEAR);

    // Job FSM and datapath; rsp_count doubles as the hit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            word      <= '0;
            bit_cnt   <= '0;
            det_i     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        word   <= req_data[32'(gnt_idx)*WORD_W +: WORD_W];
                        rsp_id <= gnt_idx;
                        rr_ptr <= ID_W'((32'(gnt_idx) + 32'd1) % NREQ);
                        busy   <= 1'b1;
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    rsp_count <= '0;
                    bit_cnt   <= BIT_W'(WORD_W - 1);
                    det_i     <= word[WORD_W-1];
                    state     <= SHIFT;
                end
                SHIFT: begin
                    // det_out in the first shift cycle still reflects the cleared detector.
                    if (bit_cnt != BIT_W'(WORD_W - 1) && det_out)
                        rsp_count <= rsp_count + CNT_W'(1);
                    if (bit_cnt == '0) begin
                        det_i <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        det_i   <= word[bit_cnt - BIT_W'(1)];
                        bit_cnt <= bit_cnt - BIT_W'(1);
                    end
                end
                DRAIN: begin
                    if (det_out)
                        rsp_count <= rsp_count + CNT_W'(1);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler with a behavioural 5-state detector
// (S0..S4, registered hit when the next state is S4).
module tb_seq_detect_scheduler;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned WORD_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*WORD_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   det_i;
    logic                   det_reset;
    logic                   det_out = 1'b0;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [CNT_W-1:0]       rsp_count;
    logic                   rsp_ready = 1'b0;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    seq_detect_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_i     (det_i),
        .det_reset (det_reset),
        .det_out   (det_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Detector transition table: hit on "11" from reset, and on a 0 after S3.
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd4 : 3'd2;
            3'd2:    return b ? 3'd3 : 3'd0;
            3'd3:    return b ? 3'd3 : 3'd4;
            default: return b ? 3'd3 : 3'd2;
        endcase
    endfunction

    logic [2:0] dstate = 3'd0;
    always_ff @(posedge clock) begin
        if (det_reset) begin
            dstate  <= 3'd0;
            det_out <= 1'b0;
        end else begin
            dstate  <= det_next(dstate, det_i);
            det_out <= (det_next(dstate, det_i) == 3'd4);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic grant_wait(output logic [3:0] rr);
        rr = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready != 4'b0) begin
                rr = req_ready;
                break;
            end
            @(posedge clock);
            #1;
        end
    endtask

    // Leaves the grant cycle, applies the post-grant request vector, and counts
    // cycles from the grant until rsp_valid is seen.
    task automatic wait_rsp(input logic [3:0] after_valid, output int n);
        n = 1;
        step();
        req_valid = after_valid;
        while (rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic set_word(input int k, input logic [7:0] w);
        req_data = (req_data & ~(32'hFF << (k * 8))) | (32'(w) << (k * 8));
    endtask

    task automatic job(input int k, input logic [7:0] w, input int exp_cnt, input string tag);
        logic [3:0] rr;
        int n;
        set_word(k, w);
        req_valid = 4'(1 << k);
        rsp_ready = 1'b1;
        grant_wait(rr);
        chk({tag, "_grant"}, 32'(rr), 32'(1 << k));
        wait_rsp(4'b0, n);
        chk({tag, "_latency"}, 32'(n), 32'd11);
        chk({tag, "_id"}, 32'(rsp_id), 32'(k));
        chk({tag, "_count"}, 32'(rsp_count), 32'(exp_cnt));
        step();
        chk({tag, "_idle"}, 32'({busy, rsp_valid}), 32'd0);
    endtask

    initial begin
        logic [3:0] rr;
        int n;
        int seen;
        int rot_cnt[4];
        rot_cnt = '{2, 0, 1, 1};

        // Reset with all requesters asking: nothing may be accepted.
        reset = 1'b1;
        req_valid = 4'hF;
        step();
        step();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_det_reset", 32'(det_reset), 32'd1);
        chk("rst_det_i", 32'(det_i), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_count", 32'(rsp_count), 32'd0);
        reset = 1'b0;
        req_valid = 4'h0;

        // Only requester 3 with rr_ptr at 0; pointer then wraps to 0.
        job(3, 8'hA0, 1, "wrap3");

        // All four continuously valid: 0,1,2,3,0.
        req_data = 32'hA0FF00D8;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            grant_wait(rr);
            chk("rot_grant", 32'(rr), 32'(1 << (j % 4)));
            wait_rsp(4'hF, n);
            chk("rot_latency", 32'(n), 32'd11);
            chk("rot_id", 32'(rsp_id), 32'(j % 4));
            chk("rot_count", 32'(rsp_count), 32'(rot_cnt[j % 4]));
            step();
        end
        req_valid = 4'h0;
        step();

        job(0, 8'b1101_1000, 2, "single");
        job(2, 8'h00, 0, "pat00");
        job(2, 8'hFF, 1, "patFF");
        job(2, 8'b1010_0000, 1, "patA0");
        job(2, 8'b1100_0000, 1, "patC0");

        // Consumer stalls in RESP while requester 0 waits.
        set_word(1, 8'b1101_1000);
        set_word(0, 8'b1101_1000);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        grant_wait(rr);
        chk("hold_grant", 32'(rr), 32'h2);
        wait_rsp(4'b0001, n);
        chk("hold_latency", 32'(n), 32'd11);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_id", 32'(rsp_id), 32'd1);
            chk("hold_count", 32'(rsp_count), 32'd2);
            chk("hold_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_no_ready", 32'(req_ready), 32'd0);
        step();
        #1;
        chk("post_hs_grant", 32'(req_ready), 32'h1);
        wait_rsp(4'b0, n);
        chk("post_hs_latency", 32'(n), 32'd11);
        chk("post_hs_id", 32'(rsp_id), 32'd0);
        chk("post_hs_count", 32'(rsp_count), 32'd2);
        step();

        // Reset during the fourth shift cycle abandons the job.
        set_word(2, 8'b1101_1000);
        req_valid = 4'b0100;
        grant_wait(rr);
        chk("mr_grant", 32'(rr), 32'h4);
        step();
        req_valid = 4'b0;
        chk("mr_clear_det_reset", 32'(det_reset), 32'd1);
        chk("mr_clear_det_i", 32'(det_i), 32'd0);
        step();
        chk("mr_shift1_det_i", 32'(det_i), 32'd1);
        chk("mr_shift1_det_reset", 32'(det_reset), 32'd0);
        step();
        chk("mr_shift2_det_i", 32'(det_i), 32'd1);
        step();
        chk("mr_shift3_det_i", 32'(det_i), 32'd0);
        step();
        chk("mr_shift4_det_i", 32'(det_i), 32'd1);
        reset = 1'b1;
        step();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_det_reset", 32'(det_reset), 32'd1);
        chk("mr_det_i", 32'(det_i), 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        chk("mr_no_rsp", 32'(seen), 32'd0);
        job(2, 8'b1101_1000, 2, "rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
